mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 198 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply / restoring divide unit
// Signed operation is compiled in only when MULT_DIV_SIGNED_EN is defined.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Op,
  input  logic             Signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] High,
  output logic [WIDTH-1:0] Low
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic             div_zero_q, div_zero_d;
  logic             done_q, done_d;

  logic             start_ok;
  logic             start_div_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] fix_high, fix_low;

  assign start_ok       = (state_q == S_IDLE) && Start;
  assign start_div_zero = Op && (B == '0);

`ifdef MULT_DIV_SIGNED_EN
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               a_neg, b_neg;
  logic [2*WIDTH-1:0] prod_fix;

  assign a_neg = Signed && A[WIDTH-1];
  assign b_neg = Signed && B[WIDTH-1];
  assign a_mag = a_neg ? (-A) : A;
  assign b_mag = b_neg ? (-B) : B;

  // Product and quotient share the XOR sign; the remainder follows the dividend.
  always_comb begin
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    if (start_ok) begin
      neg_lo_d = a_neg ^ b_neg;
      neg_hi_d = a_neg;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
    end
  end

  assign prod_fix = neg_lo_q ? (-{rem_q, quo_q}) : {rem_q, quo_q};
  assign fix_high = op_q ? (neg_hi_q ? (-rem_q) : rem_q) : prod_fix[2*WIDTH-1:WIDTH];
  assign fix_low  = op_q ? (neg_lo_q ? (-quo_q) : quo_q) : prod_fix[WIDTH-1:0];
`else
  logic signed_unused;

  assign signed_unused = Signed;
  assign a_mag         = A;
  assign b_mag         = B;
  assign fix_high      = rem_q;
  assign fix_low       = quo_q;
`endif

  // rem_q is the running upper half (multiply) or partial remainder (divide).
  assign mul_sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
  assign div_shift = {rem_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opd_q};

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d = start_div_zero ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    Busy    = (state_q != S_IDLE);
    Done    = done_q;
    DivZero = div_zero_q;
    High    = high_q;
    Low     = low_q;
  end

  always_comb begin
    op_d       = op_q;
    cnt_d      = cnt_q;
    opd_d      = opd_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    high_d     = high_q;
    low_d      = low_q;
    div_zero_d = div_zero_q;
    done_d     = (state_q == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d       = Op;
          cnt_d      = CW'(WIDTH);
          rem_d      = '0;
          div_zero_d = start_div_zero;
          opd_d      = Op ? b_mag : a_mag;
          quo_d      = Op ? a_mag : b_mag;
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_q) begin
          if (!div_diff[WIDTH]) begin
            rem_d = div_diff[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = div_shift[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          rem_d = mul_sum[WIDTH:1];
          quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
        end
      end
      S_FIX: begin
        high_d = fix_high;
        low_d  = fix_low;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      op_q       <= 1'b0;
      cnt_q      <= '0;
      opd_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      high_q     <= '0;
      low_q      <= '0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      opd_q      <= opd_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      high_q     <= high_d;
      low_q      <= low_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (WIDTH=32)
module tb_mult_div_unit;

  localparam int W = 32;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic         Op;
  logic         Signed;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] High;
  logic [W-1:0] Low;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .Op     (Op),
    .Signed (Signed),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .Done   (Done),
    .DivZero(DivZero),
    .High   (High),
    .Low    (Low)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_model(input bit op, input bit sg, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] hi,
                                    output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    bit          s;
`ifdef MULT_DIV_SIGNED_EN
    s = sg;
`else
    s = 1'b0;
`endif
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    if (!op) begin
      p = 64'(sa * sb);
    end else begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  task automatic do_op(input bit op, input bit sg, input logic [31:0] a,
                       input logic [31:0] b, input string tag);
    logic [31:0] eh, el;
    bit          dz;
    int          cyc;
    dz = op && (b == 0);
    if (dz) begin
      eh = exp_hi;
      el = exp_lo;
    end else begin
      ref_model(op, sg, a, b, eh, el);
    end
    @(negedge Clk);
    Start = 1'b1; Op = op; Signed = sg; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; A = $urandom; B = $urandom; Signed = ~sg;
    check({tag, "_busy"}, Busy, 1);
    check({tag, "_dz_accept"}, DivZero, dz);
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
    end while (!Done && cyc < 100);
    check({tag, "_latency"}, cyc, dz ? 1 : W + 2);
    check({tag, "_high"}, High, eh);
    check({tag, "_low"}, Low, el);
    check({tag, "_divzero"}, DivZero, dz);
    check({tag, "_idle"}, Busy, 0);
    exp_hi = eh;
    exp_lo = el;
  endtask

  initial begin
    logic [31:0] ra, rb, eh, el;
    bit          rop, rsg;
    int          cyc;

    Reset = 1'b0; Start = 1'b0; Op = 1'b0; Signed = 1'b0; A = '0; B = '0;
    #1;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_divzero", DivZero, 0);
    check("rst_high", High, 0);
    check("rst_low", Low, 0);
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b1;

    do_op(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "umul_max");
    check("umul_max_high_const", High, 32'hFFFF_FFFE);
    check("umul_max_low_const", Low, 32'h0000_0001);
    @(posedge Clk);
    #1;
    check("done_one_cycle", Done, 0);

    do_op(0, 1, 32'hFFFF_FFFD, 32'd7, "smul_neg");
`ifdef MULT_DIV_SIGNED_EN
    check("smul_neg_high_const", High, 32'hFFFF_FFFF);
    check("smul_neg_low_const", Low, 32'hFFFF_FFEB);
`endif
    do_op(1, 1, 32'hFFFF_FFF9, 32'd2, "sdiv_neg");
`ifdef MULT_DIV_SIGNED_EN
    check("sdiv_neg_low_const", Low, 32'hFFFF_FFFD);
    check("sdiv_neg_high_const", High, 32'hFFFF_FFFF);
`endif
    do_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, "sdiv_min");
`ifdef MULT_DIV_SIGNED_EN
    check("sdiv_min_low_const", Low, 32'h8000_0000);
    check("sdiv_min_high_const", High, 32'h0000_0000);
`endif

    do_op(1, 0, 32'h0000_2211, 32'h0000_0100, "udiv_prep");
    check("udiv_prep_high_const", High, 32'h11);
    check("udiv_prep_low_const", Low, 32'h22);
    do_op(1, 0, 32'd5, 32'd0, "divzero");
    check("divzero_high_const", High, 32'h11);
    check("divzero_low_const", Low, 32'h22);
    do_op(0, 0, 32'd3, 32'd4, "dz_clear");

    for (int i = 0; i < 40; i++) begin
      rop = 1'($urandom);
      rsg = 1'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
        3: begin rb = {28'hFFFF_FFF, 4'($urandom)}; end
        default: ;
      endcase
      do_op(rop, rsg, ra, rb, $sformatf("rand%0d", i));
    end

    ref_model(0, 0, 32'd1234, 32'd5678, eh, el);
    @(negedge Clk);
    Start = 1'b1; Op = 1'b0; Signed = 1'b0; A = 32'd1234; B = 32'd5678;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
      Start = (cyc == 5);
      if (cyc == 5) begin
        Op = 1'b1; A = 32'd5; B = 32'd0;
      end
    end while (!Done && cyc < 100);
    check("busy_start_latency", cyc, W + 2);
    check("busy_start_high", High, eh);
    check("busy_start_low", Low, el);
    check("busy_start_divzero", DivZero, 0);

    @(negedge Clk);
    Start = 1'b1; Op = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("async_rst_busy", Busy, 0);
    check("async_rst_done", Done, 0);
    check("async_rst_divzero", DivZero, 0);
    check("async_rst_high", High, 0);
    check("async_rst_low", Low, 0);
    exp_hi = '0;
    exp_lo = '0;
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    do_op(1, 0, 32'd1000, 32'd7, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
